mm_bst_arbiter: RTL and testbench

- Two-port arbiter that shares one burst MemoryMapped master port (addr/bcnt/wreq/wdat/rreq/rdat/rval/busy) between two requesters, e.g. two ps_mm_bst_buffer instances on one memory.
- Round-robin grant, locked for whole write bursts.
- Read responses returned to the issuing port in order via an internal tracking FIFO.
- Forwarding is combinational (zero added request latency); grant bookkeeping is registered.

---
 rtl/mm_bst_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mm_bst_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bst_arbiter.sv
// Two-port round-robin arbiter for a burst MemoryMapped master port.
// Requests are forwarded combinationally; read beats are routed back in order via a tracking FIFO.
module mm_bst_arbiter #(
  parameter int AWIDTH  = 6,
  parameter int BWIDTH  = 4,
  parameter int DWIDTH  = 64,
  parameter int RDDEPTH = 4
) (
  input  logic              reset,
  input  logic              clk,
  input  logic [AWIDTH-1:0] s0_addr,
  input  logic [BWIDTH-1:0] s0_bcnt,
  input  logic              s0_wreq,
  input  logic [DWIDTH-1:0] s0_wdat,
  input  logic              s0_rreq,
  output logic [DWIDTH-1:0] s0_rdat,
  output logic              s0_rval,
  output logic              s0_busy,
  input  logic [AWIDTH-1:0] s1_addr,
  input  logic [BWIDTH-1:0] s1_bcnt,
  input  logic              s1_wreq,
  input  logic [DWIDTH-1:0] s1_wdat,
  input  logic              s1_rreq,
  output logic [DWIDTH-1:0] s1_rdat,
  output logic              s1_rval,
  output logic              s1_busy,
  output logic [AWIDTH-1:0] m_addr,
  output logic [BWIDTH-1:0] m_bcnt,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy,
  output logic              rsp_err
);

  localparam int PW = $clog2(RDDEPTH);

  typedef enum logic [1:0] {IDLE, HOLD, WBURST} state_t;

  state_t            state, state_nxt;
  logic              last, last_nxt;
  logic              gnt, gnt_nxt;
  logic [BWIDTH-1:0] left, left_nxt;

  logic [RDDEPTH-1:0] fifo_id;
  logic [BWIDTH-1:0]  fifo_bcnt [RDDEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;
  logic [BWIDTH-1:0]  rcnt;

  logic req0, req1, sel, active;
  logic wreq_sel, rreq_sel, full, empty, blk, busy_sel;
  logic w_acc, r_acc, push, pop, rval_ok, head_id;
  logic [BWIDTH-1:0] head_bcnt;

  // Port selection: round-robin in IDLE, frozen on gnt in HOLD/WBURST
  always_comb begin
    req0   = s0_wreq | s0_rreq;
    req1   = s1_wreq | s1_rreq;
    sel    = 1'b0;
    active = 1'b0;
    if (state == IDLE) begin
      active = req0 | req1;
      sel    = (req0 & req1) ? ~last : req1;
    end else begin
      active = 1'b1;
      sel    = gnt;
    end
    if (reset) active = 1'b0;
  end

  assign wreq_sel = sel ? s1_wreq : s0_wreq;
  assign rreq_sel = (state != WBURST) & (sel ? s1_rreq : s0_rreq);
  assign full     = (count == (PW+1)'(RDDEPTH));
  assign empty    = (count == '0);
  assign blk      = rreq_sel & full;
  assign busy_sel = m_busy | blk;

  assign m_addr = sel ? s1_addr : s0_addr;
  assign m_bcnt = sel ? s1_bcnt : s0_bcnt;
  assign m_wdat = sel ? s1_wdat : s0_wdat;
  assign m_wreq = active & wreq_sel;
  assign m_rreq = active & rreq_sel & ~full;

  assign s0_busy = ~active | sel | busy_sel;
  assign s1_busy = ~active | ~sel | busy_sel;

  assign w_acc = m_wreq & ~m_busy;
  assign r_acc = m_rreq & ~m_busy;
  assign push  = r_acc & (m_bcnt != '0);

  assign head_id   = fifo_id[rd_ptr];
  assign head_bcnt = fifo_bcnt[rd_ptr];
  assign rval_ok   = m_rval & ~empty & ~reset;
  assign pop       = rval_ok & (rcnt == head_bcnt - BWIDTH'(1));

  assign s0_rdat = m_rdat;
  assign s1_rdat = m_rdat;
  assign s0_rval = rval_ok & ~head_id;
  assign s1_rval = rval_ok & head_id;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gnt_nxt   = gnt;
    left_nxt  = left;
    case (state)
      IDLE, HOLD: begin
        if (state == HOLD && !(sel ? req1 : req0)) begin
          state_nxt = IDLE;
        end else if (w_acc) begin
          if (m_bcnt > BWIDTH'(1)) begin
            state_nxt = WBURST;
            left_nxt  = m_bcnt - BWIDTH'(1);
            gnt_nxt   = sel;
          end else begin
            state_nxt = IDLE;
            last_nxt  = sel;
          end
        end else if (r_acc) begin
          state_nxt = IDLE;
          last_nxt  = sel;
        end else if (active) begin
          state_nxt = HOLD;
          gnt_nxt   = sel;
        end
      end
      WBURST: begin
        if (w_acc) begin
          left_nxt = left - BWIDTH'(1);
          if (left == BWIDTH'(1)) begin
            state_nxt = IDLE;
            last_nxt  = gnt;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt   <= 1'b0;
      left  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      gnt   <= gnt_nxt;
      left  <= left_nxt;
    end
  end

  // FIFO storage needs no reset: entries are only read while count is non-zero
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]   <= sel;
      fifo_bcnt[wr_ptr] <= m_bcnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rcnt    <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        rcnt   <= '0;
      end else if (rval_ok) begin
        rcnt <= rcnt + BWIDTH'(1);
      end
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
      if (m_rval && empty) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mm_bst_arbiter.sv
// Scoreboard bench for mm_bst_arbiter: port drivers, a memory slave model and a
// port-level reference memory that predicts every read beat returned to each port.
module tb_mm_bst_arbiter;

  localparam int AW = 6;
  localparam int BW = 4;
  localparam int DW = 64;

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
    logic [BW-1:0]  bcnt;
    int             dly;
    logic [31:0]    tag;
  } txn_t;

  typedef struct { int p; int cyc; } ev_t;
  typedef struct { int due; logic [DW-1:0] d; } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [AW-1:0] s_addr [2];
  logic [BW-1:0] s_bcnt [2];
  logic          s_wreq [2];
  logic [DW-1:0] s_wdat [2];
  logic          s_rreq [2];
  logic [DW-1:0] srd [2];
  logic          srv [2];
  logic          sb [2];

  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_bcnt;
  logic          m_wreq, m_rreq, rsp_err;
  logic [DW-1:0] m_wdat;
  logic [DW-1:0] m_rdat = '0;
  logic          m_rval = 1'b0;
  logic          m_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // control knobs owned by the main sequence
  bit            abort = 0, force_busy = 0, rand_busy = 0, rand_lat = 0, inject = 0, t3_chk = 0;
  int            lat = 3;
  logic [AW-1:0] t3_addr = '0;

  txn_t txq [2][$];
  txn_t cur [2];
  bit   drv_active [2];
  bit   driving [2];
  int   beat [2];
  int   wait_c [2];

  logic [DW-1:0] rdq [2][$];
  logic [DW-1:0] ref_mem [64] = '{default: '0};
  logic [DW-1:0] mem [64]     = '{default: '0};
  int            rw_left [2];
  int            rw_i [2];
  logic [AW-1:0] rw_base [2];
  ev_t glog[$], ralog[$], rvlog[$];

  rsp_t          rspq[$];
  int            wb_left = 0, wb_i = 0, last_due = 0, m_wcount = 0;
  logic [AW-1:0] wb_base = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mm_bst_arbiter #(.AWIDTH(AW), .BWIDTH(BW), .DWIDTH(DW), .RDDEPTH(4)) dut (
    .reset(reset), .clk(clk),
    .s0_addr(s_addr[0]), .s0_bcnt(s_bcnt[0]), .s0_wreq(s_wreq[0]), .s0_wdat(s_wdat[0]),
    .s0_rreq(s_rreq[0]), .s0_rdat(srd[0]), .s0_rval(srv[0]), .s0_busy(sb[0]),
    .s1_addr(s_addr[1]), .s1_bcnt(s_bcnt[1]), .s1_wreq(s_wreq[1]), .s1_wdat(s_wdat[1]),
    .s1_rreq(s_rreq[1]), .s1_rdat(srd[1]), .s1_rval(srv[1]), .s1_busy(sb[1]),
    .m_addr(m_addr), .m_bcnt(m_bcnt), .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq),
    .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy), .rsp_err(rsp_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(bit wr, int addr, int bcnt, int dly);
    txn_t t;
    t.wr = wr; t.addr = AW'(addr); t.bcnt = BW'(bcnt); t.dly = dly; t.tag = $urandom;
    return t;
  endfunction

  function automatic bit quiet();
    return txq[0].size() == 0 && txq[1].size() == 0 && !drv_active[0] && !drv_active[1] &&
           rdq[0].size() == 0 && rdq[1].size() == 0 && rspq.size() == 0;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!quiet() && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain", quiet(), 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_logs();
    glog.delete(); ralog.delete(); rvlog.delete();
  endtask

  // Port drivers: drive at posedge+1, learn acceptance at the negedge
  initial begin : drivers
    for (int p = 0; p < 2; p++) begin
      cur[p] = mk(0, 0, 1, 0);
      drv_active[p] = 0; driving[p] = 0; beat[p] = 0; wait_c[p] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (abort) begin
          txq[p].delete();
          drv_active[p] = 0;
        end
        if (!drv_active[p] && txq[p].size() > 0) begin
          cur[p] = txq[p].pop_front();
          drv_active[p] = 1; beat[p] = 0; wait_c[p] = cur[p].dly;
        end
        driving[p] = 0;
        if (drv_active[p] && wait_c[p] > 0) wait_c[p]--;
        else if (drv_active[p]) driving[p] = 1;
        s_wreq[p] = driving[p] & cur[p].wr;
        s_rreq[p] = driving[p] & !cur[p].wr;
        s_addr[p] = cur[p].addr;
        s_bcnt[p] = cur[p].bcnt;
        s_wdat[p] = {cur[p].tag, 32'(beat[p])};
      end
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (driving[p] && !sb[p]) begin
          beat[p]++;
          if (!cur[p].wr || beat[p] >= int'(cur[p].bcnt)) drv_active[p] = 0;
        end
      end
    end
  end

  // Monitor: port-level reference memory and per-port read-data scoreboards
  always @(negedge clk) begin : monitor
    bit aw [2];
    bit ar [2];
    logic [AW-1:0] a;
    if (reset) begin
      rw_left[0] = 0; rw_left[1] = 0;
      rdq[0].delete(); rdq[1].delete();
    end else begin
      for (int p = 0; p < 2; p++) begin
        aw[p] = s_wreq[p] && !sb[p];
        ar[p] = s_rreq[p] && !sb[p];
        if (aw[p]) begin
          glog.push_back('{p: p, cyc: cyc});
          if (rw_left[p] == 0) begin
            rw_base[p] = s_addr[p];
            rw_left[p] = (s_bcnt[p] == 0) ? 1 : int'(s_bcnt[p]);
            rw_i[p] = 0;
          end
          a = rw_base[p] + AW'(rw_i[p]);
          ref_mem[a] = s_wdat[p];
          rw_i[p]++; rw_left[p]--;
        end
        if (ar[p]) begin
          ralog.push_back('{p: p, cyc: cyc});
          for (int i = 0; i < int'(s_bcnt[p]); i++) begin
            a = s_addr[p] + AW'(i);
            rdq[p].push_back(ref_mem[a]);
          end
        end
        if (srv[p]) begin
          rvlog.push_back('{p: p, cyc: cyc});
          chk(p == 0 ? "rval_expected_s0" : "rval_expected_s1", rdq[p].size() > 0, 1);
          if (rdq[p].size() > 0) chk(p == 0 ? "rdat_s0" : "rdat_s1", srd[p], rdq[p].pop_front());
        end
      end
      if (s_wreq[0] | s_rreq[0] | s_wreq[1] | s_rreq[1])
        chk("one_grant", (aw[0] | ar[0]) & (aw[1] | ar[1]), 0);
      if (t3_chk && m_busy) chk("hold_addr", {m_wreq, m_addr}, {1'b1, t3_addr});
    end
  end

  // Memory slave: captures at the negedge, answers with in-order latency
  always @(negedge clk) begin : slave_cap
    int due;
    if (reset) begin
      rspq.delete(); wb_left = 0; last_due = 0;
    end else begin
      if (m_wreq && !m_busy) begin
        if (wb_left == 0) begin
          wb_base = m_addr;
          wb_left = (m_bcnt == 0) ? 1 : int'(m_bcnt);
          wb_i = 0;
        end
        mem[wb_base + AW'(wb_i)] = m_wdat;
        wb_i++; wb_left--; m_wcount++;
      end
      if (m_rreq && !m_busy) begin
        due = cyc + (rand_lat ? int'($urandom_range(1, 6)) : lat);
        if (due <= last_due) due = last_due + 1;
        for (int i = 0; i < int'(m_bcnt); i++)
          rspq.push_back('{due: due + i, d: mem[m_addr + AW'(i)]});
        last_due = due + int'(m_bcnt) - 1;
      end
    end
  end

  always @(posedge clk) begin : slave_drv
    #1;
    m_rval = 1'b0;
    if (!reset) begin
      if (inject) begin
        m_rval = 1'b1;
        m_rdat = {$urandom, $urandom};
      end else if (rspq.size() > 0 && rspq[0].due <= cyc) begin
        m_rval = 1'b1;
        m_rdat = rspq[0].d;
        void'(rspq.pop_front());
      end
    end
    m_busy = force_busy || (rand_busy && $urandom_range(0, 3) == 0);
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wc0, ncnt, nm;
    repeat (3) @(posedge clk);
    #4;
    chk("rst_m_wreq", m_wreq, 0);
    chk("rst_busy", {sb[0], sb[1]}, 2'b11);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #3; reset = 0;
    repeat (2) @(posedge clk);

    // T1: both ports stream single-beat writes, grants must alternate starting with port 0
    clear_logs();
    wc0 = m_wcount;
    for (int i = 0; i < 4; i++) begin
      txq[0].push_back(mk(1, i, 1, 0));
      txq[1].push_back(mk(1, 8 + i, 1, 0));
    end
    wait_idle(200);
    chk("t1_count", glog.size(), 8);
    chk("t1_mem_beats", m_wcount - wc0, 8);
    ncnt = 0;
    for (int i = 0; i < glog.size(); i++) begin
      chk("t1_order", glog[i].p, i % 2);
      if (glog[i].p == 0) ncnt++;
    end
    chk("t1_port0_writes", ncnt, 4);

    // T2: port 0 four-beat burst locks out port 1, which follows right after the last beat
    clear_logs();
    txq[0].push_back(mk(1, 32, 4, 0));
    txq[1].push_back(mk(1, 40, 1, 1));
    wait_idle(200);
    chk("t2_count", glog.size(), 5);
    if (glog.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t2_order", glog[i].p, (i < 4) ? 0 : 1);
      chk("t2_burst_len", glog[3].cyc - glog[0].cyc, 3);
      chk("t2_next_grant", glog[4].cyc, glog[3].cyc + 1);
    end

    // T3: leave last=0 so only the frozen grant keeps port 0 ahead while the slave stalls
    txq[0].push_back(mk(1, 60, 1, 0));
    wait_idle(100);
    clear_logs();
    t3_addr = AW'(48);
    force_busy = 1;
    t3_chk = 1;
    txq[0].push_back(mk(1, 48, 1, 0));
    txq[1].push_back(mk(1, 50, 1, 1));
    repeat (3) @(posedge clk);
    force_busy = 0;
    t3_chk = 0;
    wait_idle(100);
    chk("t3_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t3_first", glog[0].p, 0);
      chk("t3_second", glog[1].p, 1);
    end

    // T4: reads from both ports come back to the issuing port, in order
    clear_logs();
    lat = 5;
    txq[0].push_back(mk(0, 0, 3, 0));
    txq[1].push_back(mk(0, 8, 2, 1));
    wait_idle(200);
    chk("t4_rval_count", rvlog.size(), 5);
    if (rvlog.size() == 5)
      for (int i = 0; i < 5; i++) chk("t4_rval_port", rvlog[i].p, (i < 3) ? 0 : 1);

    // T5: a fifth outstanding read waits until the first burst has fully returned
    clear_logs();
    lat = 20;
    for (int i = 0; i < 5; i++) txq[0].push_back(mk(0, 16 + 2 * i, 2, 0));
    wait_idle(400);
    chk("t5_reads", ralog.size(), 5);
    chk("t5_beats", rvlog.size(), 10);
    if (ralog.size() == 5 && rvlog.size() >= 2) begin
      chk("t5_fast_accept", ralog[3].cyc - ralog[0].cyc, 3);
      chk("t5_blocked_until_pop", ralog[4].cyc, rvlog[1].cyc + 1);
    end

    // T6: stray response sets the sticky error without reaching a port
    lat = 3;
    chk("t6_err_before", rsp_err, 0);
    inject = 1;
    @(negedge clk);
    chk("t6_no_rval", {srv[0], srv[1]}, 2'b00);
    @(posedge clk);
    inject = 0;
    @(negedge clk);
    chk("t6_err_set", rsp_err, 1);
    repeat (2) @(posedge clk);
    chk("t6_err_sticky", rsp_err, 1);

    // reset in the middle of a write burst, then a fresh transaction
    txq[0].push_back(mk(1, 24, 4, 0));
    repeat (3) @(posedge clk);
    #3; reset = 1; abort = 1;
    #1;
    chk("mid_rst_m_wreq", m_wreq, 0);
    chk("mid_rst_m_rreq", m_rreq, 0);
    chk("mid_rst_busy", {sb[0], sb[1]}, 2'b11);
    chk("mid_rst_rval", {srv[0], srv[1]}, 2'b00);
    chk("mid_rst_err", rsp_err, 0);
    repeat (2) @(posedge clk);
    #3; reset = 0; abort = 0;
    repeat (2) @(posedge clk);
    clear_logs();
    txq[0].push_back(mk(1, 24, 2, 0));
    txq[1].push_back(mk(0, 24, 2, 4));
    wait_idle(200);
    chk("post_rst_writes", glog.size(), 2);
    chk("post_rst_reads", rvlog.size(), 2);

    // randomized traffic with slave back-pressure and variable latency
    rand_busy = 1;
    rand_lat = 1;
    for (int k = 0; k < 40; k++)
      for (int p = 0; p < 2; p++)
        txq[p].push_back(mk(bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                            int'($urandom_range(1, 4)), int'($urandom_range(0, 3))));
    wait_idle(6000);
    rand_busy = 0;
    rand_lat = 0;
    repeat (2) @(posedge clk);
    nm = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) nm++;
    chk("mem_match", nm, 0);
    chk("final_err_clear", rsp_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
